// File: rtl/tgl_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
// Optional event counter enabled by defining TGL_RX_CNT_EN.
package tgl_pkg;

  typedef enum logic [0:0] {
    TGL_IDLE  = 1'b0,
    TGL_VALID = 1'b1
  } tgl_state_e;

  localparam int TGL_SYNC_DEFAULT = 2;
  localparam int TGL_CNT_W        = 16;

endpackage

// File: rtl/tgl_hs_rx_sync.sv
// N-stage flop chain for bringing a toggle level into the clk domain.
// Also usable on the sender side to synchronise ack_tgl.
module tgl_sync
  import tgl_pkg::*;
#(
  parameter int SYNC_STAGES = TGL_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tgl_hs_rx.sv
// Two-phase toggle receiver: decodes req_tgl edges into valid/ready words.
// Define TGL_RX_CNT_EN to add the evt_cnt accepted-word counter.
module tgl_hs_rx
  import tgl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = TGL_SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic              err_proto
`ifdef TGL_RX_CNT_EN
  ,
  output logic [TGL_CNT_W-1:0] evt_cnt
`endif
);

  tgl_state_e state;
  logic       req_s;
  logic       req_last;
  logic       evt;
  logic       accept;

  tgl_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_tgl),
    .q  (req_s)
  );

  assign evt    = req_s ^ req_last;
  assign accept = out_valid & out_ready;

  // req_last only advances on capture, so an early toggle stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TGL_IDLE;
      req_last  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ack_tgl   <= 1'b0;
    end else begin
      case (state)
        TGL_IDLE: begin
          if (evt) begin
            out_data  <= data_in;
            req_last  <= req_s;
            out_valid <= 1'b1;
            state     <= TGL_VALID;
          end
        end
        TGL_VALID: begin
          if (accept) begin
            out_valid <= 1'b0;
            ack_tgl   <= ~ack_tgl;
            state     <= TGL_IDLE;
          end
        end
        default: state <= TGL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_proto <= 1'b0;
    end else if ((state == TGL_VALID) && evt) begin
      err_proto <= 1'b1;
    end else if (err_clr) begin
      err_proto <= 1'b0;
    end
  end

`ifdef TGL_RX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (accept) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tgl_hs_rx.sv
// Scoreboard bench for tgl_hs_rx: reset, single, stream, back-pressure,
// protocol violation and (with TGL_RX_CNT_EN) the event counter.
module tb_tgl_hs_rx;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_tgl;
  logic [DW-1:0] data_in;
  logic          ack_tgl;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          err_clr;
  logic          err_proto;
`ifdef TGL_RX_CNT_EN
  logic [15:0]   evt_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  tgl_hs_rx #(
    .DATA_W     (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_tgl  (req_tgl),
    .data_in  (data_in),
    .ack_tgl  (ack_tgl),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .err_clr  (err_clr),
    .err_proto(err_proto)
`ifdef TGL_RX_CNT_EN
    ,
    .evt_cnt  (evt_cnt)
`endif
  );

  task automatic send(input logic [DW-1:0] d);
    data_in = d;
    req_tgl = ~req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset;
    int n;
    logic [DW-1:0] e;
    n_checks++;
    if ({ack_tgl, out_valid, out_data, err_proto} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: ack=%b vld=%b data=%h err=%b, required all 0",
               ack_tgl, out_valid, out_data, err_proto);
    end
    rst = 1'b0;
    send(8'h5A);
    wait_valid(10, n);
    send(8'h77);
    repeat (4) @(negedge clk);
    n_checks++;
    if (err_proto !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: err=%b vld=%b, required 1 1",
               err_proto, out_valid);
    end
    req_tgl = 1'b1;
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ack_tgl, out_valid, out_data, err_proto} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: ack=%b vld=%b data=%h err=%b, required all 0",
               ack_tgl, out_valid, out_data, err_proto);
    end
`ifdef TGL_RX_CNT_EN
    n_checks++;
    if (evt_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: evt_cnt=%0d, required 0", evt_cnt);
    end
`endif
    data_in = 8'hC3;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'hC3);
    wait_valid(10, n);
    n_checks++;
    if (n !== SS + 1) begin
      n_fail++;
      $display("FAIL reset_latency: %0d edges, required %0d", n, SS + 1);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_data !== e) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h, required %h", out_data, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (ack_tgl !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: ack=%b vld=%b, required 1 0",
               ack_tgl, out_valid);
    end
  endtask

  task automatic test_single;
    int n;
    logic a;
    logic [DW-1:0] e;
    out_ready = 1'b1;
    a = ack_tgl;
    send(8'hA5);
    wait_valid(10, n);
    n_checks++;
    if (n !== SS + 1) begin
      n_fail++;
      $display("FAIL single_latency: %0d edges, required %0d", n, SS + 1);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_data !== e || ack_tgl !== a) begin
      n_fail++;
      $display("FAIL single_data: data=%h ack=%b, required %h %b",
               out_data, ack_tgl, e, a);
    end
    @(negedge clk);
    n_checks++;
    if (ack_tgl !== ~a || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b vld=%b, required %b 0",
               ack_tgl, out_valid, ~a);
    end
  endtask

  task automatic test_stream;
    int n;
    int w;
    logic [DW-1:0] e;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send(DW'(i));
      wait_valid(10, n);
      e = exp_q.pop_front();
      n_checks++;
      if (n < 0 || out_data !== e) begin
        n_fail++;
        $display("FAIL stream_word%0d: data=%h wait=%0d, required %h",
                 i, out_data, n, e);
      end
      w = 0;
      while (ack_tgl !== req_tgl && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    n_checks++;
    if (ack_tgl !== 1'b1 || err_proto !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: ack=%b err=%b vld=%b, required 1 0 0",
               ack_tgl, err_proto, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic a;
    logic [DW-1:0] e;
    out_ready = 1'b0;
    a = ack_tgl;
    send(8'h3C);
    wait_valid(10, n);
    e = exp_q.pop_front();
    n_checks++;
    if (n < 0 || out_data !== e) begin
      n_fail++;
      $display("FAIL bp_data: data=%h wait=%0d, required %h", out_data, n, e);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e || ack_tgl !== a) begin
        n_fail++;
        $display("FAIL bp_hold%0d: vld=%b data=%h ack=%b, required 1 %h %b",
                 c, out_valid, out_data, ack_tgl, e, a);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (ack_tgl !== ~a || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: ack=%b vld=%b, required %b 0",
               ack_tgl, out_valid, ~a);
    end
  endtask

  task automatic test_violation;
    int n;
    logic a;
    logic [DW-1:0] e;
    out_ready = 1'b0;
    a = ack_tgl;
    send(8'h11);
    wait_valid(10, n);
    n_checks++;
    if (n < 0 || err_proto !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_first: wait=%0d err=%b, required err 0", n, err_proto);
    end
    send(8'h22);
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (err_proto !== 1'b1 || out_valid !== 1'b1 || out_data !== e) begin
      n_fail++;
      $display("FAIL viol_flag: err=%b vld=%b data=%h, required 1 1 %h",
               err_proto, out_valid, out_data, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || ack_tgl !== ~a) begin
      n_fail++;
      $display("FAIL viol_accept1: vld=%b ack=%b, required 0 %b",
               out_valid, ack_tgl, ~a);
    end
    wait_valid(10, n);
    n_checks++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL viol_recapture: %0d edges, required 1", n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_data !== e || err_proto !== 1'b1) begin
      n_fail++;
      $display("FAIL viol_second: data=%h err=%b, required %h 1",
               out_data, err_proto, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (ack_tgl !== a || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_accept2: ack=%b vld=%b, required %b 0",
               ack_tgl, out_valid, a);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (err_proto !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_clear: err=%b, required 0", err_proto);
    end
  endtask

`ifdef TGL_RX_CNT_EN
  task automatic test_counter;
    int n;
    int w;
    logic [DW-1:0] e;
    n_checks++;
    if (evt_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL cnt_start: evt_cnt=%0d, required 8", evt_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(DW'(8'h40 + i));
      wait_valid(10, n);
      e = exp_q.pop_front();
      w = 0;
      while (ack_tgl !== req_tgl && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (evt_cnt !== 16'd13) begin
      n_fail++;
      $display("FAIL cnt_end: evt_cnt=%0d, required 13", evt_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_tgl   = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_violation();
`ifdef TGL_RX_CNT_EN
    test_counter();
`endif
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d words left, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
